// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared definitions for the DIV/HI/LO sequencer.
//   - DivWidth    : default operand/quotient/remainder width.
//   - div_state_e : sequencer state encoding (Idle=0, Calc=1, Fixup=2).
package div_sequencer_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [1:0] {
        DivIdle  = 2'd0,
        DivCalc  = 2'd1,
        DivFixup = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sequencer_div_step.sv
// div_sequencer_div_step: one combinational radix-2 restoring-divide iteration.
// Shifts {rem, quo} left by one, trial-subtracts the divisor magnitude from the
// widened remainder and records the outcome in the quotient LSB.
// Ports:
//   rem_i / quo_i : current partial remainder and quotient/dividend shift reg
//   dvs_i         : divisor magnitude
//   rem_o / quo_o : values after this iteration
module div_sequencer_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        // Compare at WIDTH+1 bits so a 2^(WIDTH-1) or larger divisor is exact.
        ge      = (shifted >= {1'b0, dvs_i});
        // When ge holds the true difference is below dvs_i, so WIDTH bits suffice.
        diff    = shifted[WIDTH-1:0] - dvs_i;
        rem_o   = ge ? diff : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV sequencer owning the HI/LO register pair.
// Runs a restoring divide (one quotient bit per cycle), sign-corrects, then
// commits LO = quotient, HI = remainder. Produces the decode stall for
// MFHI/MFLO/DIV while a divide is in flight.
// Optional build macro: DIV_UNSIGNED_EN adds div_unsigned (DIVU support).
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   div_start                 : execute-stage DIV strobe
//   div_unsigned              : (DIV_UNSIGNED_EN only) treat operands as unsigned
//   dividend, divisor         : execute-stage rs/rt operands
//   is_mf_hi_d/is_mf_lo_d/has_div_d : decode-stage hazard sources
//   stall_d                   : fetch/decode stall
//   busy                      : divide in flight
//   hi, lo                    : HI/LO registers
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             div_start,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_mf_hi_d,
    input  logic             is_mf_lo_d,
    input  logic             has_div_d,
    output logic             stall_d,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             quo_neg_q, quo_neg_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             dvd_sign;
    logic             dvs_sign;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

`ifdef DIV_UNSIGNED_EN
    assign dvd_sign = dividend[WIDTH-1] & ~div_unsigned;
    assign dvs_sign = divisor[WIDTH-1] & ~div_unsigned;
`else
    assign dvd_sign = dividend[WIDTH-1];
    assign dvs_sign = divisor[WIDTH-1];
`endif

    div_sequencer_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_neg_d = dvd_neg_q;
        quo_neg_d = quo_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            DivIdle: begin
                if (div_start) begin
                    dvd_neg_d = dvd_sign;
                    quo_neg_d = dvd_sign ^ dvs_sign;
                    quo_d     = dvd_sign ? -dividend : dividend;
                    dvs_d     = dvs_sign ? -divisor : divisor;
                    div0_d    = (divisor == '0);
                    rem_d     = '0;
                    count_d   = '0;
                    state_d   = DivCalc;
                end
            end
            DivCalc: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DivFixup;
                end
            end
            DivFixup: begin
                lo_d = div0_q ? '1 : (quo_neg_q ? -quo_q : quo_q);
                // With a zero divisor every trial subtract succeeds, so rem ends
                // as |dividend| and the sign fix-up restores the original dividend.
                hi_d    = dvd_neg_q ? -rem_q : rem_q;
                state_d = DivIdle;
            end
            default: begin
                state_d = DivIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DivIdle;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_neg_q <= dvd_neg_d;
            quo_neg_q <= quo_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = (state_q != DivIdle);
    // div_start term catches a dependent instruction right behind a DIV in execute.
    assign stall_d = (busy | div_start) & (is_mf_hi_d | is_mf_lo_d | has_div_d);
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer.
// Build with DIV_UNSIGNED_EN defined to also exercise DIVU.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        div_start;
    logic        div_unsigned;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_mf_hi_d;
    logic        is_mf_lo_d;
    logic        has_div_d;
    logic        stall_d;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_asserts = 0;
    int n_fail    = 0;

    div_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .div_start    (div_start),
`ifdef DIV_UNSIGNED_EN
        .div_unsigned (div_unsigned),
`endif
        .dividend     (dividend),
        .divisor      (divisor),
        .is_mf_hi_d   (is_mf_hi_d),
        .is_mf_lo_d   (is_mf_lo_d),
        .has_div_d    (has_div_d),
        .stall_d      (stall_d),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one divide (caller sits 1 time unit after an edge) and checks the
    // 33-edge latency, HI/LO hold, stall behaviour and the committed result.
    // poke pulses a stray div_start mid-divide, which must be ignored.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input bit poke,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        logic [31:0] old_lo;
        logic [31:0] old_hi;
        logic        exp_stall;
        int          bad_busy;
        int          bad_hold;
        int          bad_stall;
        old_lo    = lo;
        old_hi    = hi;
        exp_stall = is_mf_hi_d | is_mf_lo_d | has_div_d;
        bad_busy  = 0;
        bad_hold  = 0;
        bad_stall = 0;
        dividend     = a;
        divisor      = b;
        div_unsigned = uns;
        div_start    = 1'b1;
        #1;
        if (stall_d !== exp_stall) bad_stall++;
        tick();
        div_start = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0003;
        for (int i = 0; i <= 32; i++) begin
            if (i > 0) tick();
            if (busy !== 1'b1) bad_busy++;
            if (lo !== old_lo || hi !== old_hi) bad_hold++;
            if (stall_d !== exp_stall) bad_stall++;
            if (poke && i == 10) begin
                div_start = 1'b1;
                dividend  = 32'h0000_0040;
                divisor   = 32'h0000_0002;
            end else begin
                div_start = 1'b0;
            end
        end
        tick();
        check({tag, "_busy_window"}, 32'(bad_busy), 32'd0);
        check({tag, "_hold"}, 32'(bad_hold), 32'd0);
        check({tag, "_stall_window"}, 32'(bad_stall), 32'd0);
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, "_stall_drop"}, {31'd0, stall_d}, 32'd0);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
    endtask

    initial begin
        reset_n      = 1'b0;
        div_start    = 1'b0;
        div_unsigned = 1'b0;
        dividend     = '0;
        divisor      = '0;
        is_mf_hi_d   = 1'b1;
        is_mf_lo_d   = 1'b0;
        has_div_d    = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_d}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        is_mf_hi_d = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Signed divides.
        run_div("s_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2);
        run_div("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

        // Async reset ten edges into a divide.
        has_div_d = 1'b1;
        dividend  = 32'd1234;
        divisor   = 32'd7;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, stall_d}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        has_div_d = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Divide by zero and INT_MIN / -1.
        run_div("div0_pos", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        run_div("div0_neg", 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run_div("intmin", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 32'd0);

        // MFLO in decode alongside the DIV strobe.
        is_mf_lo_d = 1'b1;
        run_div("mflo_haz", 32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 32'd0);
        is_mf_lo_d = 1'b0;

        // Back-to-back: second DIV held in decode, stray strobe mid-divide.
        has_div_d = 1'b1;
        run_div("b2b_first", 32'd77, 32'd5, 1'b0, 1'b1, 32'd15, 32'd2);
        run_div("b2b_second", 32'd9, 32'd4, 1'b0, 1'b0, 32'd2, 32'd1);
        has_div_d = 1'b0;

`ifdef DIV_UNSIGNED_EN
        run_div("divu", 32'hFFFF_FFFE, 32'd2, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd0);
        run_div("div_same_ops", 32'hFFFF_FFFE, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
